stopwatch_bcd_counter: RTL and testbench

- Consumes the divided clock produced by the even clock divider stage and runs a BCD MM:SS stopwatch for the display stage.
- Samples the divided clock as data in the `clk_in` domain and turns each rising edge into a one-cycle tick.
- Counts ticks into seconds and minutes under a start/stop/clear control FSM.
- The divided clock is never used as a clock.

---
 rtl/stopwatch_bcd_counter.sv | 164 ++++++++++++++++
 tb/tb_stopwatch_bcd_counter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter: MM:SS BCD stopwatch driven by ticks derived from a
// divided clock that is sampled as data (it is never used as a clock).
// Optional build macro: STOPWATCH_SYNC_EN adds a two-flop synchronizer on
// tick_src, for when it comes from another clock domain (tick latency 3
// cycles instead of 1).
module stopwatch_bcd_counter #(
    parameter int unsigned TICKS_PER_SEC = 1,
    parameter int unsigned PW            = 1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_src,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       tick,
    output logic       rollover
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);

    logic          src;
    logic          src_q;
    logic          pulse_q;
    state_e        state_q, state_d;
    logic [PW-1:0] ps_q, ps_d;
    logic [3:0]    so_q, so_d, st_q, st_d, mo_q, mo_d, mt_q, mt_d;
    logic          roll_q, roll_d;

`ifdef STOPWATCH_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-flop synchronizer for a tick_src from a foreign clock domain.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= tick_src;
            sync2_q <= sync1_q;
        end
    end

    assign src = sync2_q;
`else
    assign src = tick_src;
`endif

    // Rising-edge detector: one registered pulse per low-to-high transition.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            src_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            src_q   <= src;
            pulse_q <= src & ~src_q;
        end
    end

    // Control state register.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear beats stop beats start; stop only acts in RUN.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (stop && (state_q == RUN)) begin
            state_d = PAUSE;
        end else if (start && (state_q != RUN)) begin
            state_d = RUN;
        end
    end

    // Prescaler and BCD digit registers.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            ps_q   <= '0;
            so_q   <= '0;
            st_q   <= '0;
            mo_q   <= '0;
            mt_q   <= '0;
            roll_q <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            so_q   <= so_d;
            st_q   <= st_d;
            mo_q   <= mo_d;
            mt_q   <= mt_d;
            roll_q <= roll_d;
        end
    end

    // Count ticks in RUN; prescaler is untouched outside RUN so a partial
    // second survives a pause. The ripple carry is a nested chain per digit.
    always_comb begin
        ps_d   = ps_q;
        so_d   = so_q;
        st_d   = st_q;
        mo_d   = mo_q;
        mt_d   = mt_q;
        roll_d = 1'b0;
        if (clear) begin
            ps_d = '0;
            so_d = '0;
            st_d = '0;
            mo_d = '0;
            mt_d = '0;
        end else if ((state_q == RUN) && pulse_q) begin
            if (ps_q == PS_LAST) begin
                ps_d = '0;
                if (so_q != 4'd9) begin
                    so_d = so_q + 4'd1;
                end else begin
                    so_d = '0;
                    if (st_q != 4'd5) begin
                        st_d = st_q + 4'd1;
                    end else begin
                        st_d = '0;
                        if (mo_q != 4'd9) begin
                            mo_d = mo_q + 4'd1;
                        end else begin
                            mo_d = '0;
                            if (mt_q != 4'd5) begin
                                mt_d = mt_q + 4'd1;
                            end else begin
                                mt_d   = '0;
                                roll_d = 1'b1;
                            end
                        end
                    end
                end
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end
    end

    assign running  = (state_q == RUN);
    assign tick     = pulse_q;
    assign rollover = roll_q;
    assign sec_ones = so_q;
    assign sec_tens = st_q;
    assign min_ones = mo_q;
    assign min_tens = mt_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// tb_stopwatch_bcd_counter: two stopwatch instances (1 and 4 ticks per
// second) share one stimulus stream; a tick-count reference model predicts
// every output on every cycle, alongside directed scenario checks.
module tb_stopwatch_bcd_counter;

`ifdef STOPWATCH_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic clk_in = 1'b0;
    logic reset = 1'b0;
    logic tick_src = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic clear = 1'b0;

    logic [3:0] d1_so, d1_st, d1_mo, d1_mt;
    logic       d1_run, d1_tick, d1_roll;
    logic [3:0] d4_so, d4_st, d4_mo, d4_mt;
    logic       d4_run, d4_tick, d4_roll;

    stopwatch_bcd_counter #(.TICKS_PER_SEC(1), .PW(1)) dut1 (
        .clk_in(clk_in), .reset(reset), .tick_src(tick_src),
        .start(start), .stop(stop), .clear(clear),
        .sec_ones(d1_so), .sec_tens(d1_st), .min_ones(d1_mo), .min_tens(d1_mt),
        .running(d1_run), .tick(d1_tick), .rollover(d1_roll)
    );

    stopwatch_bcd_counter #(.TICKS_PER_SEC(4), .PW(2)) dut4 (
        .clk_in(clk_in), .reset(reset), .tick_src(tick_src),
        .start(start), .stop(stop), .clear(clear),
        .sec_ones(d4_so), .sec_tens(d4_st), .min_ones(d4_mo), .min_tens(d4_mt),
        .running(d4_run), .tick(d4_tick), .rollover(d4_roll)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: counted ticks since clear, mode 0=idle 1=run 2=pause,
    // and a history of tick_src samples (newest in bit 0).
    int         cnt1 = 0, cnt4 = 0, mode = 0;
    logic       etick = 1'b0, er1 = 1'b0, er4 = 1'b0;
    logic [3:0] hist = 4'b0;

    always @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt1 = 0; cnt4 = 0; mode = 0;
            etick = 1'b0; er1 = 1'b0; er4 = 1'b0; hist = 4'b0;
        end else begin
            er1 = 1'b0;
            er4 = 1'b0;
            if (clear) begin
                cnt1 = 0; cnt4 = 0; mode = 0;
            end else begin
                if (mode == 1 && etick) begin
                    cnt1++;
                    cnt4++;
                    er1 = (cnt1 % 3600) == 0;
                    er4 = (cnt4 % (4 * 3600)) == 0;
                end
                if (stop && mode == 1) mode = 2;
                else if (start && mode != 1) mode = 1;
            end
            hist = {hist[2:0], tick_src};
            etick = hist[D] & ~hist[D+1];
        end
    end

    function automatic logic [31:0] pack(input int cnt, input int tps, input logic run,
                                         input logic tk, input logic ro);
        int s, m, sc;
        s  = (cnt / tps) % 3600;
        m  = s / 60;
        sc = s % 60;
        return {13'd0, 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10), run, tk, ro};
    endfunction

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk_in) begin
        if (chk_en) begin
            check_eq("cyc_tps1", {13'd0, d1_mt, d1_mo, d1_st, d1_so, d1_run, d1_tick, d1_roll},
                     pack(cnt1, 1, mode == 1, etick, er1));
            check_eq("cyc_tps4", {13'd0, d4_mt, d4_mo, d4_st, d4_so, d4_run, d4_tick, d4_roll},
                     pack(cnt4, 4, mode == 1, etick, er4));
        end
    end

    task automatic cyc(input logic ts, input logic st, input logic sp, input logic cl);
        tick_src = ts; start = st; stop = sp; clear = cl;
        @(negedge clk_in);
    endtask

    task automatic pulse(input int hi, input int lo);
        repeat (hi) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (lo) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        repeat (D + 3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [15:0] d1_val();
        return {d1_mt, d1_mo, d1_st, d1_so};
    endfunction

    int n, seen;
    logic got;

    initial begin
        repeat (3) @(negedge clk_in);
        chk_en = 1'b1;
        check_eq("rst_tps1", {13'd0, d1_mt, d1_mo, d1_st, d1_so, d1_run, d1_tick, d1_roll}, 32'd0);
        check_eq("rst_tps4", {13'd0, d4_mt, d4_mo, d4_st, d4_so, d4_run, d4_tick, d4_roll}, 32'd0);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Tick latency and first count at one tick per second.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        tick_src = 1'b1;
        n = 0;
        got = 1'b0;
        while (n < 10 && !got) begin
            @(posedge clk_in);
            #1;
            n++;
            if (d1_tick) got = 1'b1;
        end
        check_eq("tick_latency", n, D + 1);
        @(negedge clk_in);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("first_sec", {d1_so, 3'd0, d1_run}, {4'd1, 3'd0, 1'b1});

        // Partial second kept across a pause at four ticks per second.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) pulse(1, D + 2);
        settle();
        check_eq("tps4_3ticks", {d4_mt, d4_mo, d4_st, d4_so}, 16'h0000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) pulse(1, D + 2);
        settle();
        check_eq("tps4_paused", {d4_mt, d4_mo, d4_st, d4_so, 3'd0, d4_run}, 20'h00000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1, D + 2);
        settle();
        check_eq("tps4_4th", {d4_mt, d4_mo, d4_st, d4_so}, 16'h0001);

        // Wrap from 59:59 to 00:00.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3598) pulse(1, 1);
        settle();
        check_eq("at_5958", d1_val(), 16'h5958);
        pulse(1, 1);
        settle();
        check_eq("at_5959", d1_val(), 16'h5959);
        seen = 0;
        for (int i = 0; i < D + 6; i++) begin
            cyc(i == 0, 1'b0, 1'b0, 1'b0);
            if (d1_roll) seen++;
        end
        check_eq("rollover_cycles", seen, 1);
        check_eq("after_wrap", d1_val(), 16'h0000);

        // Stop coincident with a tick while at 00:05.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) pulse(1, 1);
        settle();
        check_eq("at_0005", d1_val(), 16'h0005);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (D) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("stop_tick", {d1_val(), 3'd0, d1_run}, {16'h0006, 4'd0});

        // Clear + start coincident with a tick while at 12:34.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (754) pulse(1, 1);
        settle();
        check_eq("at_1234", d1_val(), 16'h1234);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (D) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("clear_start_tick", {d1_val(), 3'd0, d1_run}, 20'h00000);

        // Level held high counts once.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check_eq("held_high", d1_val(), 16'h0001);

        // Asynchronous reset between clock edges at 03:27.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (207) pulse(1, 1);
        settle();
        check_eq("at_0327", d1_val(), 16'h0327);
        tick_src = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_tps1", {13'd0, d1_mt, d1_mo, d1_st, d1_so, d1_run, d1_tick, d1_roll}, 32'd0);
        check_eq("arst_tps4", {13'd0, d4_mt, d4_mo, d4_st, d4_so, d4_run, d4_tick, d4_roll}, 32'd0);
        @(negedge clk_in);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < D + 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (d1_tick) seen++;
        end
        check_eq("high_after_reset", seen, 1);

        // Randomized control and tick traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end
        settle();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
